rr_arbiter_hs: RTL and testbench

- Round-robin arbiter with valid/ready handshakes. Shares one downstream consumer between NUM_REQ requesters.
- Typical consumers are a single-ported functional unit or a writeback port in the SM pipeline.
- Search order is selectable between LSB-first and MSB-first. MSB-first is done by bit-reversing the request vector and reversing the grant back.
- Output is a one-entry registered buffer, so arbitration logic is decoupled from downstream timing.

---
 rtl/input_reverse.sv | 20 ++
 rtl/rr_find_first.sv | 41 ++++
 rtl/rr_arbiter_hs.sv | 94 +++++++++
 tb/tb_rr_arbiter_hs.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/input_reverse.sv
// +----------------------------------------------------------------------------+
// | input_reverse : bit-order reversal of a WIDTH-bit vector                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module input_reverse #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign o_data[g] = i_data[WIDTH-1-g];
    end

endmodule

`default_nettype wire

// File: rtl/rr_find_first.sv
// +----------------------------------------------------------------------------+
// | rr_find_first : two-pass masked fixed-priority search above a pointer      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_find_first #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [WIDTH-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_masked;
    logic [WIDTH-1:0] w_vec;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = (i > int'(i_ptr));
        end
        w_masked = i_req & w_mask;
        // Requests above the pointer win first; otherwise wrap to the bottom.
        w_vec    = (|w_masked) ? w_masked : i_req;
        o_idx    = '0;
        o_grant  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_grant = WIDTH'(1) << i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_hs.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter_hs : round-robin valid/ready arbiter with a one-entry out buffer|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter_hs #(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_WIDTH     = 32,
    parameter  int PRIO_MSB_FIRST = 0,
    localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [ID_W-1:0]               out_id_o,
    output logic                          busy_o
);

    // Pointer lives in the search domain; NUM_REQ-1 makes the first search
    // start at search index 0 (original index 0 in LSB mode, NUM_REQ-1 in MSB).
    localparam logic [ID_W-1:0] C_PTR_RST = ID_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]    w_req_s;
    logic [NUM_REQ-1:0]    w_grant_s;
    logic [NUM_REQ-1:0]    w_ready_s;
    logic [ID_W-1:0]       w_win_s;
    logic [ID_W-1:0]       w_win_id;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic                  w_can_accept;
    logic                  w_handshake;

    logic [ID_W-1:0]       r_ptr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ID_W-1:0]       r_out_id;

    if (PRIO_MSB_FIRST != 0) begin : g_msb
        input_reverse #(.WIDTH(NUM_REQ)) u_rev_req (
            .i_data (req_valid_i),
            .o_data (w_req_s)
        );
        input_reverse #(.WIDTH(NUM_REQ)) u_rev_gnt (
            .i_data (w_ready_s),
            .o_data (req_ready_o)
        );
        assign w_win_id = C_PTR_RST - w_win_s;
    end else begin : g_lsb
        assign w_req_s     = req_valid_i;
        assign req_ready_o = w_ready_s;
        assign w_win_id    = w_win_s;
    end

    rr_find_first #(.WIDTH(NUM_REQ)) u_find (
        .i_req   (w_req_s),
        .i_ptr   (r_ptr),
        .o_grant (w_grant_s),
        .o_idx   (w_win_s)
    );

    assign w_can_accept = !r_out_valid || out_ready_i;
    assign w_ready_s    = w_grant_s & {NUM_REQ{w_can_accept}};
    assign w_handshake  = |(req_valid_i & req_ready_o);
    assign w_win_data   = req_data_i[int'(w_win_id)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= C_PTR_RST;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
        end else if (w_handshake) begin
            r_ptr       <= w_win_s;
            r_out_valid <= 1'b1;
            r_out_data  <= w_win_data;
            r_out_id    <= w_win_id;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_id_o    = r_out_id;
    assign busy_o      = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_hs.sv
// +----------------------------------------------------------------------------+
// | tb_rr_arbiter_hs : scoreboard bench for LSB-first and MSB-first builds     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rr_arbiter_hs;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic            out_ready;

    logic [N-1:0]    rdy0, rdy1;
    logic            ov0, ov1, busy0, busy1;
    logic [DW-1:0]   od0, od1;
    logic [IW-1:0]   oid0, oid1;

    always #5 clk = ~clk;

    rr_arbiter_hs #(.NUM_REQ(N), .DATA_WIDTH(DW), .PRIO_MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(rdy0), .out_valid_o(ov0), .out_ready_i(out_ready),
        .out_data_o(od0), .out_id_o(oid0), .busy_o(busy0)
    );

    rr_arbiter_hs #(.NUM_REQ(N), .DATA_WIDTH(DW), .PRIO_MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(rdy1), .out_valid_o(ov1), .out_ready_i(out_ready),
        .out_data_o(od1), .out_id_o(oid1), .busy_o(busy1)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_ptr   [2];
    logic        m_valid [2];
    int          waits   [2][N];
    logic [33:0] q0[$];
    logic [33:0] q1[$];
    bit          rand_data = 1'b0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin in original index order: mode 0 ascends, mode 1 descends.
    function automatic int model_pick(input int mode, input logic [N-1:0] v, input int ptr);
        int idx;
        for (int s = 1; s <= N; s++) begin
            idx = (mode != 0) ? (ptr - s + N) % N : (ptr + s) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_ptr[0]   = N - 1;
        m_ptr[1]   = 0;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < N; k++) waits[d][k] = 0;
    endtask

    task automatic model_check(input int d);
        logic [N-1:0]  rdy, exp_g;
        logic          ov, bz;
        logic [DW-1:0] od;
        logic [IW-1:0] oid;
        logic [33:0]   front;
        int            w, qsize;
        bit            can;
        rdy   = (d != 0) ? rdy1  : rdy0;
        ov    = (d != 0) ? ov1   : ov0;
        bz    = (d != 0) ? busy1 : busy0;
        od    = (d != 0) ? od1   : od0;
        oid   = (d != 0) ? oid1  : oid0;
        can   = !m_valid[d] || out_ready;
        w     = can ? model_pick(d, req_valid, m_ptr[d]) : -1;
        exp_g = '0;
        if (w >= 0) exp_g[w] = 1'b1;
        chk_eq($sformatf("d%0d ready", d), rdy, exp_g);
        chk_eq($sformatf("d%0d valid", d), ov, m_valid[d]);
        chk_eq($sformatf("d%0d busy", d), bz, m_valid[d]);
        if (m_valid[d]) begin
            qsize = (d != 0) ? q1.size() : q0.size();
            chk_eq($sformatf("d%0d sb_size", d), qsize, 1);
            if (qsize > 0) begin
                front = (d != 0) ? q1[0] : q0[0];
                chk_eq($sformatf("d%0d out_id", d), oid, front[33:32]);
                chk_eq($sformatf("d%0d out_data", d), od, front[31:0]);
                if (out_ready) begin
                    if (d != 0) void'(q1.pop_front());
                    else        void'(q0.pop_front());
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!req_valid[k] || rdy[k]) begin
                waits[d][k] = 0;
            end else if (rdy != '0) begin
                waits[d][k]++;
                chk_eq($sformatf("d%0d fair%0d", d, k), waits[d][k] < N, 1);
            end
        end
        if (w >= 0) begin
            front = {IW'(w), req_data[w*DW +: DW]};
            if (d != 0) q1.push_back(front);
            else        q0.push_back(front);
            m_valid[d] = 1'b1;
            m_ptr[d]   = w;
        end else if (out_ready) begin
            m_valid[d] = 1'b0;
        end
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic rst);
        @(negedge clk);
        rst_n     = !rst;
        req_valid = v;
        out_ready = rdy;
        for (int k = 0; k < N; k++)
            req_data[k*DW +: DW] = rand_data ? DW'($urandom) : (32'hA000_0000 | DW'(k));
        #1;
        if (rst) begin
            model_reset();
        end else begin
            model_check(0);
            model_check(1);
        end
    endtask

    logic [N-1:0] seq_lsb [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] seq_msb [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [N-1:0] seq_alt [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        model_reset();
        cycle('0, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1);

        cycle('0, 1'b1, 1'b0);
        chk_eq("rst out_valid", ov0, 0);
        chk_eq("rst out_data", od0, 0);
        chk_eq("rst out_id", oid0, 0);
        chk_eq("rst msb out_data", od1, 0);

        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            chk_eq($sformatf("lsb_seq%0d", i), rdy0, seq_lsb[i]);
            chk_eq($sformatf("msb_seq%0d", i), rdy1, seq_msb[i]);
        end
        cycle(4'b1111, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b0, 1'b0);
            chk_eq("bp ready", rdy0, 0);
            chk_eq("bp data", od0, 32'hA000_0001);
        end
        cycle(4'b1111, 1'b1, 1'b0);
        chk_eq("bp release", rdy0, 4'b0100);

        for (int i = 0; i < 4; i++) begin
            cycle(4'b0100, 1'b1, 1'b0);
            chk_eq("single ready", rdy0, 4'b0100);
        end
        cycle(4'b0100, 1'b1, 1'b0);
        chk_eq("single id", oid0, 2);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0101, 1'b1, 1'b0);
            chk_eq($sformatf("alt%0d", i), rdy0, seq_alt[i]);
        end

        cycle(4'b0110, 1'b1, 1'b0);
        cycle(4'b0110, 1'b1, 1'b1);
        cycle(4'b0110, 1'b1, 1'b0);
        chk_eq("midrst valid", ov0, 0);
        chk_eq("midrst lsb grant", rdy0, 4'b0010);
        chk_eq("midrst msb grant", rdy1, 4'b0100);

        rand_data = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [N-1:0] v;
            for (int k = 0; k < N; k++) v[k] = ($urandom_range(0, 3) != 0);
            cycle(v, $urandom_range(0, 3) != 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
